music_fetcher: RTL
==================

Name: music_fetcher

Overview:
- Consumer end of the fetcher control interface: obeys sample_freq_div, pause, forward and fetcher_reset from the keyboard/speed controller.
- Reads 32-bit song words from flash over an Avalon-MM pipelined read port and splits each word into two 16-bit samples.
- Emits the upper byte of each sample to the audio path, one sample per rate tick.

Parameters:
- ADDR_W, 23, flash word-address width.
- LAST_ADDR, 23'h7FFFF, last word address of the song; the playback wrap point.
- SAMPLE_W, 8, output sample width, taken from bits [15:8] of each 16-bit half.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sample_freq_div  input  32  clk cycles per sample tick; 0 is treated as 1.
- pause  input  1  level; high freezes playback.
- forward  input  1  level; 1 = ascending addresses, 0 = descending.
- fetcher_reset  input  1  one-cycle pulse; restart the song.
- flash_read  output  1  Avalon read request.
- flash_address  output  ADDR_W  word address.
- flash_waitrequest  input  1  slave stall.
- flash_readdata  input  32  read data.
- flash_readdatavalid  input  1  qualifies flash_readdata.
- audio_sample  output  SAMPLE_W  current sample, held between ticks.
- sample_valid  output  1  one-cycle pulse when audio_sample updates.

Behaviour:
- Reset (async, rst_n=0): state IDLE; flash_read=0, flash_address=0, audio_sample=0, sample_valid=0, tick counter=0, dir latch=1.
- Tick generator: counter increments each clk while pause=0. When counter >= div_eff-1, where div_eff = max(div,1):
  - assert internal tick for one cycle;
  - clear the counter.
  - The >= comparison makes a shrinking divisor take effect with no long wrap.
- pause=1: counter holds, no ticks, audio_sample holds, sample_valid stays 0. An in-flight flash transaction still completes.
- FSM states:
  - IDLE -> FETCH unconditionally on the next cycle.
  - FETCH: flash_read=1 with flash_address stable. When waitrequest=0 -> WAIT_DATA, and flash_read drops the same edge.
  - WAIT_DATA: on readdatavalid, latch the word -> PLAY_A.
  - PLAY_A: on tick, output the first half -> PLAY_B.
    - Forward: first half = word[15:0], output word[15:8].
    - Backward: first half = word[31:16], output word[31:24].
  - PLAY_B: on tick, output the other half. Then advance the address and go to FETCH.
  - DRAIN: wait for readdatavalid, discard the data -> FETCH.
- Sample output timing: audio_sample and sample_valid update on the clk edge after the tick cycle.
- Direction:
  - forward is latched into the dir latch only at a word boundary (leaving PLAY_B, or on a restart).
  - A mid-word change finishes the current word in the old order.
- Address advance:
  - dir=1: LAST_ADDR wraps to 0, otherwise +1.
  - dir=0: 0 wraps to LAST_ADDR, otherwise -1.
- Tick arriving while in FETCH or WAIT_DATA (flash too slow): the tick is dropped and no sample is emitted. Tick is not queued.
- fetcher_reset, from any state:
  - latch dir=forward;
  - address = 0 if forward=1, else LAST_ADDR;
  - clear the tick counter.
  - Next state: DRAIN if in WAIT_DATA (outstanding read must not be mistaken for the new word); otherwise FETCH.
  - If pulsed in FETCH while waitrequest=0 the read was accepted, so go to DRAIN.
  - audio_sample holds its last value.
- Simultaneous fetcher_reset and tick: the reset wins and no sample is emitted.
- flash_address changes only when flash_read=0.

Decomposition:
- Shared package music_pkg:
  - state enum {IDLE, FETCH, WAIT_DATA, DRAIN, PLAY_A, PLAY_B};
  - LAST_ADDR default;
  - scan-code constants already used by the controller.
- One sub-module, sample_tick_gen: divisor counter plus pause gating; outputs tick.

Test Plan:
- Reset, then waitrequest=0 and readdatavalid 2 cycles after each accept, div=4, forward=1, word0=32'hAABB_CCDD -> flash_read rises 1 cycle after reset release at address 0. Samples 8'hCC then 8'hAA on ticks 4 clk apart, then a read at address 1.
- forward=0 after fetcher_reset, word=32'h1122_3344 at LAST_ADDR -> output 8'h11 then 8'h33, next read at LAST_ADDR-1. At address 0, the next read is at LAST_ADDR.
- Forward playback reaching LAST_ADDR -> next flash_address=0.
- pause=1 for 20 cycles mid-word -> no sample_valid, audio_sample constant. After release the next sample arrives exactly 4 clk later with div=4.
- fetcher_reset pulsed in WAIT_DATA, stale readdatavalid carrying 32'hDEAD_BEEF -> that word is never output; next read is at address 0.
- div changed 100 -> 2 mid-count (counter at 50) -> tick on the next cycle, then every 2 cycles. div=0 -> tick every cycle, capped by flash latency with no lockup.

Source files
------------

// File: rtl/music_pkg.sv
// Shared definitions for the music player: fetcher FSM states, song
// geometry defaults and the keyboard scan codes the controller decodes.
package music_pkg;

  localparam int          ADDR_W_DEF    = 23;
  localparam logic [22:0] LAST_ADDR_DEF = 23'h7FFFF;
  localparam int          SAMPLE_W_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    DRAIN,
    PLAY_A,
    PLAY_B
  } fetch_state_t;

  // PS/2 set-2 make codes recognised by the keyboard/speed controller
  localparam logic [7:0] SCAN_D = 8'h23;  // pause
  localparam logic [7:0] SCAN_E = 8'h24;  // play
  localparam logic [7:0] SCAN_F = 8'h2B;  // play forward
  localparam logic [7:0] SCAN_B = 8'h32;  // play backward
  localparam logic [7:0] SCAN_R = 8'h2D;  // restart song

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate tick generator: one-cycle tick every div clocks (0 acts as 1),
// frozen while paused, restartable by clear.
module sample_tick_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] div,
  input  logic        pause,
  input  logic        clear,
  output logic        tick
);

  logic [31:0] count_reg;
  logic [31:0] count_next;
  logic [31:0] limit;

  // Terminal count uses >= so a divisor that shrinks below the current
  // count fires immediately instead of wrapping all the way round.
  always_comb begin
    limit      = (div == 32'd0) ? 32'd0 : div - 32'd1;
    tick       = !pause && (count_reg >= limit);
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (tick) begin
      count_next = '0;
    end else if (!pause) begin
      count_next = count_reg + 32'd1;
    end
  end

  // Divisor counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/music_fetcher.sv
// Song fetcher: reads 32-bit words from flash over Avalon-MM, splits each
// into two 16-bit samples and emits their upper bytes at the sample rate.
module music_fetcher
  import music_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_ADDR_DEF),
  parameter int                SAMPLE_W  = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         sample_freq_div,
  input  logic                pause,
  input  logic                forward,
  input  logic                fetcher_reset,
  output logic                flash_read,
  output logic [ADDR_W-1:0]   flash_address,
  input  logic                flash_waitrequest,
  input  logic [31:0]         flash_readdata,
  input  logic                flash_readdatavalid,
  output logic [SAMPLE_W-1:0] audio_sample,
  output logic                sample_valid
);

  fetch_state_t        state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next, addr_step;
  logic                dir_reg, dir_next;
  logic [31:0]         word_reg, word_next;
  logic [SAMPLE_W-1:0] audio_reg, audio_next;
  logic                valid_reg, valid_next;
  logic                tick;
  logic [SAMPLE_W-1:0] lo_sample, hi_sample;

  sample_tick_gen u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (sample_freq_div),
    .pause (pause),
    .clear (fetcher_reset),
    .tick  (tick)
  );

  assign lo_sample     = word_reg[15 -: SAMPLE_W];
  assign hi_sample     = word_reg[31 -: SAMPLE_W];
  assign flash_read    = (state_reg == FETCH);
  assign flash_address = addr_reg;
  assign audio_sample  = audio_reg;
  assign sample_valid  = valid_reg;

  // Next word address in the newly latched direction, wrapping at the song ends
  always_comb begin
    if (forward) begin
      addr_step = (addr_reg == LAST_ADDR) ? '0 : addr_reg + ADDR_W'(1);
    end else begin
      addr_step = (addr_reg == '0) ? LAST_ADDR : addr_reg - ADDR_W'(1);
    end
  end

  // Fetch/play sequencing; restart overrides normal flow and any tick
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    dir_next   = dir_reg;
    word_next  = word_reg;
    audio_next = audio_reg;
    valid_next = 1'b0;
    case (state_reg)
      IDLE:      state_next = FETCH;
      FETCH:     if (!flash_waitrequest) state_next = WAIT_DATA;
      WAIT_DATA: if (flash_readdatavalid) begin
                   word_next  = flash_readdata;
                   state_next = PLAY_A;
                 end
      DRAIN:     if (flash_readdatavalid) state_next = FETCH;
      PLAY_A:    if (tick) begin
                   audio_next = dir_reg ? lo_sample : hi_sample;
                   valid_next = 1'b1;
                   state_next = PLAY_B;
                 end
      PLAY_B:    if (tick) begin
                   audio_next = dir_reg ? hi_sample : lo_sample;
                   valid_next = 1'b1;
                   dir_next   = forward;
                   addr_next  = addr_step;
                   state_next = FETCH;
                 end
      default:   state_next = IDLE;
    endcase
    if (fetcher_reset) begin
      word_next  = word_reg;
      audio_next = audio_reg;
      valid_next = 1'b0;
      dir_next   = forward;
      addr_next  = forward ? '0 : LAST_ADDR;
      case (state_reg)
        // A read is still outstanding: its data belongs to the old song
        // position, so throw it away (at once if it is arriving right now).
        WAIT_DATA, DRAIN: state_next = flash_readdatavalid ? FETCH : DRAIN;
        // Accepted this edge -> drain it; still stalled -> withdraw the
        // request for one cycle so the address never moves under a read.
        FETCH:            state_next = flash_waitrequest ? IDLE : DRAIN;
        default:          state_next = FETCH;
      endcase
    end
  end

  // State, address, direction, word and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      dir_reg   <= 1'b1;
      word_reg  <= '0;
      audio_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      dir_reg   <= dir_next;
      word_reg  <= word_next;
      audio_reg <= audio_next;
      valid_reg <= valid_next;
    end
  end

endmodule
